// File: rtl/npu_mem_arbiter.sv
// Single-port matrix memory arbiter between the host loader (H) and the systolic controller (N).
// Combinational same-cycle grants, N burst lock with timeout, tagged read return.
module npu_mem_arbiter #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [WIDTH-1:0]  h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    input  logic              n_req,
    input  logic              n_we,
    input  logic [ADDR_W-1:0] n_addr,
    input  logic [WIDTH-1:0]  n_wdata,
    input  logic              n_lock,
    output logic              n_gnt,
    output logic              n_rvalid,
    output logic [WIDTH-1:0]  rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [1:0]        owner,
    output logic [15:0]       stall_count
);

    localparam int unsigned CNT_W  = $clog2(MAX_LOCK + 1);
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_H = 2'b01,
        OWN_N = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic               last_n_q, last_n_d;
    logic               lock_q, lock_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [RD_LAT-1:0]  tag_h_q, tag_n_q;
    logic               locked;

    // N holds the port only if it asked for the lock on its previous grant.
    assign locked = (state_q == OWN_N) && lock_q;

    // State and bookkeeping registers, including the read-tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_n_q   <= 1'b0;
            lock_q     <= 1'b0;
            lock_cnt_q <= '0;
            stall_q    <= '0;
            tag_h_q    <= '0;
            tag_n_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_n_q   <= last_n_d;
            lock_q     <= lock_d;
            lock_cnt_q <= lock_cnt_d;
            stall_q    <= stall_d;
            tag_h_q[0] <= h_gnt & ~h_we;
            tag_n_q[0] <= n_gnt & ~n_we;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_h_q[i] <= tag_h_q[i-1];
                tag_n_q[i] <= tag_n_q[i-1];
            end
        end
    end

    // Next state, round-robin history, lock accounting and stall counter.
    always_comb begin
        state_d    = IDLE;
        last_n_d   = last_n_q;
        lock_d     = 1'b0;
        lock_cnt_d = '0;
        stall_d    = stall_q;
        if (h_gnt) begin
            state_d  = OWN_H;
            last_n_d = 1'b0;
        end else if (n_gnt) begin
            state_d  = OWN_N;
            last_n_d = 1'b1;
            lock_d   = n_lock;
            if (n_lock) begin
                lock_cnt_d = (locked && h_req) ? lock_cnt_q + CNT_W'(1) : lock_cnt_q;
            end
        end
        if (((h_req && !h_gnt) || (n_req && !n_gnt)) && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // Grant decision and memory steering; nothing is granted while in reset.
    always_comb begin
        h_gnt     = 1'b0;
        n_gnt     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (h_req && n_req) begin
                if (locked) begin
                    if (lock_cnt_q == CNT_W'(MAX_LOCK)) h_gnt = 1'b1;
                    else                                n_gnt = 1'b1;
                end else if (last_n_q) begin
                    h_gnt = 1'b1;
                end else begin
                    n_gnt = 1'b1;
                end
            end else begin
                h_gnt = h_req;
                n_gnt = n_req;
            end
        end
        if (h_gnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (n_gnt) begin
            mem_we    = n_we;
            mem_addr  = n_addr;
            mem_wdata = n_wdata;
        end
    end

    assign h_rvalid    = tag_h_q[RD_LAT-1];
    assign n_rvalid    = tag_n_q[RD_LAT-1];
    assign rdata       = mem_rdata;
    assign owner       = state_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_npu_mem_arbiter.sv
// Randomized and directed bench for npu_mem_arbiter against a behavioural arbitration model.
module tb_npu_mem_arbiter;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned MAX_LOCK = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              h_req = 1'b0, h_we = 1'b0, n_req = 1'b0, n_we = 1'b0, n_lock = 1'b0;
    logic [ADDR_W-1:0] h_addr = '0, n_addr = '0;
    logic [WIDTH-1:0]  h_wdata = '0, n_wdata = '0;
    logic              h_gnt, n_gnt, h_rvalid, n_rvalid, mem_we;
    logic [WIDTH-1:0]  rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        owner;
    logic [15:0]       stall_count;

    npu_mem_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)) dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .n_req(n_req), .n_we(n_we), .n_addr(n_addr), .n_wdata(n_wdata), .n_lock(n_lock),
        .n_gnt(n_gnt), .n_rvalid(n_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Memory the arbiter drives: single port, RD_LAT-cycle read pipeline.
    logic [WIDTH-1:0] bmem [4096];
    logic [WIDTH-1:0] rpipe [RD_LAT];
    assign mem_rdata = rpipe[RD_LAT-1];
    always @(posedge clk) begin
        if (mem_we) bmem[mem_addr] <= mem_wdata;
        rpipe[0] <= bmem[mem_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    // Behavioural model: owner 0 none / 1 H / 2 N, last grantee, lock, timeout count.
    int               m_own, m_last, m_cnt;
    bit               m_lock;
    int               m_stall;
    logic [WIDTH-1:0] mm [4096];
    bit               ring_h [8];
    bit               ring_n [8];
    logic [WIDTH-1:0] ring_d [8];
    int               cyc_n;

    int checks = 0;
    int errors = 0;

    logic        obs_hg, obs_ng, obs_hv, obs_nv, obs_mwe;
    logic [15:0] obs_rd, obs_stall;
    logic [11:0] obs_maddr;
    logic [1:0]  obs_owner;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 1; m_cnt = 0; m_lock = 0; m_stall = 0;
        for (int i = 0; i < 8; i++) begin
            ring_h[i] = 0; ring_n[i] = 0; ring_d[i] = '0;
        end
    endtask

    task automatic cyc(input logic r, input logic hq, input logic hw, input logic [11:0] ha,
                       input logic [15:0] hd, input logic nq, input logic nw, input logic [11:0] na,
                       input logic [15:0] nd, input logic nl);
        bit eh, en, locked, ev_h, ev_n;
        logic [15:0] ev_d;
        int slot;
        @(posedge clk);
        #1;
        rst = r; h_req = hq; h_we = hw; h_addr = ha; h_wdata = hd;
        n_req = nq; n_we = nw; n_addr = na; n_wdata = nd; n_lock = nl;
        #5;
        eh = 0; en = 0;
        locked = (m_own == 2) && m_lock;
        if (!r) begin
            if (hq && nq) begin
                if (locked) begin
                    if (m_cnt == MAX_LOCK) eh = 1; else en = 1;
                end else if (m_last == 1) en = 1;
                else eh = 1;
            end else if (hq) eh = 1;
            else if (nq) en = 1;
        end
        slot = cyc_n % 8;
        ev_h = ring_h[slot]; ev_n = ring_n[slot]; ev_d = ring_d[slot];
        ring_h[slot] = 0; ring_n[slot] = 0;

        chk("h_gnt", 32'(h_gnt), 32'(eh));
        chk("n_gnt", 32'(n_gnt), 32'(en));
        chk("mem_we", 32'(mem_we), eh ? 32'(hw) : en ? 32'(nw) : 32'd0);
        chk("mem_addr", 32'(mem_addr), eh ? 32'(ha) : en ? 32'(na) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata), eh ? 32'(hd) : en ? 32'(nd) : 32'd0);
        chk("owner", 32'(owner), 32'(m_own));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("h_rvalid", 32'(h_rvalid), 32'(ev_h));
        chk("n_rvalid", 32'(n_rvalid), 32'(ev_n));
        if (ev_h || ev_n) chk("rdata", 32'(rdata), 32'(ev_d));

        obs_hg = h_gnt; obs_ng = n_gnt; obs_hv = h_rvalid; obs_nv = n_rvalid;
        obs_mwe = mem_we; obs_rd = rdata; obs_stall = stall_count;
        obs_maddr = mem_addr; obs_owner = owner;

        if (r) begin
            model_reset();
        end else begin
            if (((hq && !eh) || (nq && !en)) && m_stall != 65535) m_stall++;
            if (en && nl && locked && hq) m_cnt++;
            else if (!(en && nl)) m_cnt = 0;
            if (eh) m_last = 1;
            if (en) m_last = 2;
            m_own  = eh ? 1 : en ? 2 : 0;
            m_lock = en && nl;
            if (eh && !hw) begin
                ring_h[(cyc_n + RD_LAT) % 8] = 1; ring_d[(cyc_n + RD_LAT) % 8] = mm[ha];
            end
            if (en && !nw) begin
                ring_n[(cyc_n + RD_LAT) % 8] = 1; ring_d[(cyc_n + RD_LAT) % 8] = mm[na];
            end
            if (eh && hw) mm[ha] = hd;
            if (en && nw) mm[na] = nd;
        end
        cyc_n++;
    endtask

    task automatic do_rst();
        cyc(1, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 12'h0, 16'h0, 0, 0, 12'h0, 16'h0, 0);
    endtask

    logic [7:0] pat_h, pat_n, pat_hv, pat_nv;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            bmem[i] = 16'($urandom);
            mm[i]   = bmem[i];
        end
        cyc_n = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and single host read
        idle();
        chk("rst_owner", 32'(obs_owner), 32'd0);
        chk("rst_stall", 32'(obs_stall), 32'd0);
        cyc(0, 1, 0, 12'h010, 16'h0, 0, 0, 12'h0, 16'h0, 0);
        chk("t1_hgnt", 32'(obs_hg), 32'd1);
        chk("t1_addr", 32'(obs_maddr), 32'h010);
        chk("t1_we", 32'(obs_mwe), 32'd0);
        idle();
        idle();
        chk("t1_hrvalid", 32'(obs_hv), 32'd1);
        chk("t1_nrvalid", 32'(obs_nv), 32'd0);

        // Round-robin with both requesting, last=H after reset
        do_rst();
        pat_h = '0; pat_n = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 12'(i), 16'h0, 1, 0, 12'(i + 8), 16'h0, 0);
            pat_h = {pat_h[6:0], obs_hg}; pat_n = {pat_n[6:0], obs_ng};
        end
        chk("t2_hpat", 32'(pat_h), 32'h05);
        chk("t2_npat", 32'(pat_n), 32'h0A);
        idle();
        chk("t2_stall", 32'(obs_stall), 32'd4);

        // Lock timeout lets H in on cycle 6
        do_rst();
        pat_h = '0; pat_n = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 12'h020, 16'h0, 1, 0, 12'h030, 16'h0, 1);
            pat_h = {pat_h[6:0], obs_hg}; pat_n = {pat_n[6:0], obs_ng};
        end
        chk("t3_hpat", 32'(pat_h), 32'h04);
        chk("t3_npat", 32'(pat_n), 32'hFB);

        // N write then H read of the same word
        do_rst();
        cyc(0, 0, 0, 12'h0, 16'h0, 1, 1, 12'h100, 16'h7FFF, 0);
        chk("t4_we1", 32'(obs_mwe), 32'd1);
        cyc(0, 1, 0, 12'h100, 16'h0, 0, 0, 12'h0, 16'h0, 0);
        chk("t4_we0", 32'(obs_mwe), 32'd0);
        idle();
        chk("t4_nv_a", 32'(obs_nv), 32'd0);
        idle();
        chk("t4_hv", 32'(obs_hv), 32'd1);
        chk("t4_rdata", 32'(obs_rd), 32'h7FFF);
        chk("t4_nv_b", 32'(obs_nv), 32'd0);

        // Alternating reads return in issue order
        do_rst();
        pat_hv = '0; pat_nv = '0;
        cyc(0, 1, 0, 12'h001, 16'h0, 0, 0, 12'h0, 16'h0, 0);
        pat_hv = {pat_hv[6:0], obs_hv}; pat_nv = {pat_nv[6:0], obs_nv};
        cyc(0, 0, 0, 12'h0, 16'h0, 1, 0, 12'h002, 16'h0, 0);
        pat_hv = {pat_hv[6:0], obs_hv}; pat_nv = {pat_nv[6:0], obs_nv};
        cyc(0, 1, 0, 12'h003, 16'h0, 0, 0, 12'h0, 16'h0, 0);
        pat_hv = {pat_hv[6:0], obs_hv}; pat_nv = {pat_nv[6:0], obs_nv};
        for (int i = 0; i < 2; i++) begin
            idle();
            pat_hv = {pat_hv[6:0], obs_hv}; pat_nv = {pat_nv[6:0], obs_nv};
        end
        chk("t5_hv", 32'(pat_hv), 32'h05);
        chk("t5_nv", 32'(pat_nv), 32'h02);

        // Reset discards an in-flight N read
        do_rst();
        cyc(0, 0, 0, 12'h0, 16'h0, 1, 0, 12'h040, 16'h0, 0);
        do_rst();
        idle();
        chk("t6_nv", 32'(obs_nv), 32'd0);
        chk("t6_owner", 32'(obs_owner), 32'd0);
        chk("t6_stall", 32'(obs_stall), 32'd0);
        idle();
        chk("t6_nv2", 32'(obs_nv), 32'd0);

        // Randomized traffic on a small address window
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_rst();
            end else begin
                cyc(0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0, 12'($urandom_range(0, 15)),
                    16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
                    12'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 9) < 7);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
